vga_timing_ctrl: RTL and testbench

- Sequences the pixel colour datapath.
- Generates the horizontal/vertical scan counters, sync pulses and active-region flag that drive the colour generator's video_on, pixel_x and pixel_y inputs.
- Runs on the 25 MHz pixel clock; default timing is 640x480 @ 60 Hz.
- Also emits frame/line strobes for downstream logic such as the frame-buffer reader and the pattern controller.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_timing_ctrl_mod_counter.sv | 27 ++
 rtl/vga_timing_ctrl.sv | 99 +++++++++
 tb/tb_vga_timing_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA scan timing block.
// Default values describe 640x480 @ 60 Hz on a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    localparam int unsigned DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test: lo <= cnt < hi
    function automatic logic in_window(cnt_t cnt, cnt_t lo, cnt_t hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_mod_counter.sv
// Modulo-N up-counter with synchronous reset, count enable and terminal-count flag.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = CNT_W
) (
    input  logic         clk_d,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk_d) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing: h/v counters, sync pulses, active-region flag and line/frame strobes.
// Define VGA_SYNC_ALIGN_EN to register hsync/vsync one extra clk_d to match registered RGB.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS    = DEF_H_VIS,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_VIS    = DEF_V_VIS,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk_d,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_end,
    output logic             frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if ((H_TOT > CNT_MAX) || (V_TOT > CNT_MAX) || (H_TOT < 2) || (V_TOT < 1)
        || (H_VIS == 0) || (V_VIS == 0)) begin : g_param_err
        $error("vga_timing_ctrl: timing totals must lie in range and fit the counter width");
    end

    localparam cnt_t H_VIS_C = CNT_W'(H_VIS);
    localparam cnt_t V_VIS_C = CNT_W'(V_VIS);
    localparam cnt_t HS_LO   = CNT_W'(H_VIS + H_FP);
    localparam cnt_t HS_HI   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t VS_LO   = CNT_W'(V_VIS + V_FP);
    localparam cnt_t VS_HI   = CNT_W'(V_VIS + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_tc;
    logic v_tc;
    logic hs_lvl;
    logic vs_lvl;

    mod_counter #(.N(H_TOT), .W(CNT_W)) u_h_cnt (
        .clk_d (clk_d),
        .rst   (rst),
        .en    (1'b1),
        .count (h_cnt),
        .tc    (h_tc)
    );

    mod_counter #(.N(V_TOT), .W(CNT_W)) u_v_cnt (
        .clk_d (clk_d),
        .rst   (rst),
        .en    (h_tc),
        .count (v_cnt),
        .tc    (v_tc)
    );

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign video_on    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign line_end    = h_tc;
    assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !rst;

    assign hs_lvl = in_window(h_cnt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    assign vs_lvl = in_window(v_cnt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_q;
    logic vs_q;

    always_ff @(posedge clk_d) begin
        if (rst) begin
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            hs_q <= hs_lvl;
            vs_q <= vs_lvl;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
`else
    assign hsync = hs_lvl;
    assign vsync = vs_lvl;
`endif

    // Both counters must wrap on the same edge at the bottom-right corner
    a_corner_wrap : assert property (@(posedge clk_d) disable iff (rst)
        (h_tc && v_tc) |=> ((h_cnt == '0) && (v_cnt == '0)));

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a reduced timing set to keep frames short.
module tb_vga_timing_ctrl;
    import vga_timing_pkg::*;

    localparam int unsigned TH_VIS  = 40;
    localparam int unsigned TH_FP   = 4;
    localparam int unsigned TH_SYNC = 8;
    localparam int unsigned TH_BP   = 6;
    localparam int unsigned TV_VIS  = 20;
    localparam int unsigned TV_FP   = 2;
    localparam int unsigned TV_SYNC = 2;
    localparam int unsigned TV_BP   = 3;
    localparam bit          POL     = SYNC_ACTIVE_LOW;

    localparam int unsigned TH_TOT = TH_VIS + TH_FP + TH_SYNC + TH_BP;
    localparam int unsigned TV_TOT = TV_VIS + TV_FP + TV_SYNC + TV_BP;
    localparam int unsigned FRAME  = TH_TOT * TV_TOT;

    logic             clk_d = 1'b0;
    logic             rst   = 1'b1;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_end;
    logic             frame_start;

    always #5 clk_d = ~clk_d;

    vga_timing_ctrl #(
        .H_VIS    (TH_VIS),
        .H_FP     (TH_FP),
        .H_SYNC   (TH_SYNC),
        .H_BP     (TH_BP),
        .V_VIS    (TV_VIS),
        .V_FP     (TV_FP),
        .V_SYNC   (TV_SYNC),
        .V_BP     (TV_BP),
        .SYNC_POL (POL)
    ) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             von;
        logic [CNT_W-1:0] px;
        logic [CNT_W-1:0] py;
        logic             le;
        logic             fs;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic hs_ref(int unsigned h);
        return (h >= TH_VIS + TH_FP && h < TH_VIS + TH_FP + TH_SYNC) ? POL : ~POL;
    endfunction

    function automatic logic vs_ref(int unsigned v);
        return (v >= TV_VIS + TV_FP && v < TV_VIS + TV_FP + TV_SYNC) ? POL : ~POL;
    endfunction

    initial begin
        int unsigned mh = 0;
        int unsigned mv = 0;
        logic        hs_q = ~POL;
        logic        vs_q = ~POL;
        int unsigned mid   = 5 + FRAME + 15 * TH_TOT + 30;
        int unsigned total = mid + 2 * FRAME + 100;
        int unsigned von_cnt = 0, vs_cnt = 0, hs_cnt = 0, since_fs = 0;
        int unsigned fs_obs = 0, fs_exp = 0;
        bit          fs_seen = 0, line_clean = 0;
        exp_t        e;
        exp_t        g;

        for (int unsigned c = 0; c < total; c++) begin
            @(negedge clk_d);
            rst = (c < 5) || (c == mid);

            e.px  = CNT_W'(mh);
            e.py  = CNT_W'(mv);
            e.von = (mh < TH_VIS) && (mv < TV_VIS);
            e.le  = (mh == TH_TOT - 1);
            e.fs  = (mh == 0) && (mv == 0) && !rst;
`ifdef VGA_SYNC_ALIGN_EN
            e.hs  = hs_q;
            e.vs  = vs_q;
`else
            e.hs  = hs_ref(mh);
            e.vs  = vs_ref(mv);
`endif
            sb.push_back(e);
            fs_exp += e.fs ? 1 : 0;

            #1;
            g = sb.pop_front();
            check("pixel_x",     32'(pixel_x),     32'(g.px));
            check("pixel_y",     32'(pixel_y),     32'(g.py));
            check("video_on",    32'(video_on),    32'(g.von));
            check("hsync",       32'(hsync),       32'(g.hs));
            check("vsync",       32'(vsync),       32'(g.vs));
            check("line_end",    32'(line_end),    32'(g.le));
            check("frame_start", 32'(frame_start), 32'(g.fs));

            if (rst) begin
                fs_seen    = 0;
                hs_cnt     = 0;
                line_clean = 1;
            end else begin
                if (frame_start) begin
                    if (fs_seen) begin
                        check("frame_period",  since_fs, FRAME);
                        check("von_per_frame", von_cnt,  TH_VIS * TV_VIS);
                        check("vs_per_frame",  vs_cnt,   TV_SYNC * TH_TOT);
                    end
                    fs_seen  = 1;
                    since_fs = 0;
                    von_cnt  = 0;
                    vs_cnt   = 0;
                    fs_obs++;
                end
                since_fs++;
                von_cnt += video_on ? 1 : 0;
                vs_cnt  += (vsync == POL) ? 1 : 0;
                hs_cnt  += (hsync == POL) ? 1 : 0;
                if (line_end) begin
                    if (line_clean) check("hs_per_line", hs_cnt, TH_SYNC);
                    hs_cnt     = 0;
                    line_clean = 1;
                end
            end

            @(posedge clk_d);
            hs_q = rst ? ~POL : hs_ref(mh);
            vs_q = rst ? ~POL : vs_ref(mv);
            if (rst) begin
                mh = 0;
                mv = 0;
            end else if (mh == TH_TOT - 1) begin
                mh = 0;
                mv = (mv == TV_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end

        check("fs_count", fs_obs, fs_exp);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
